// File: rtl/inst_package.sv
// Instruction encodings shared by the VLIW decoder: opcode and execute-type enums,
// the canonical Nop word and small classification helpers.
package inst_package;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,  OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_XOR   = 6'd3,
    OP_AND   = 6'd4,  OP_ADDI  = 6'd5,  OP_LI    = 6'd6,  OP_LOAD  = 6'd7,
    OP_STORE = 6'd8,  OP_CMPD  = 6'd9,  OP_CMPDI = 6'd10, OP_CMPF  = 6'd11,
    OP_FADD  = 6'd12, OP_FSUB  = 6'd13, OP_FMUL  = 6'd14, OP_FDIV  = 6'd15,
    OP_FSQRT = 6'd16, OP_FTOI  = 6'd17, OP_ITOF  = 6'd18, OP_JUMP  = 6'd19,
    OP_BLR   = 6'd20, OP_BL    = 6'd21, OP_BLRR  = 6'd22, OP_BEQ   = 6'd23,
    OP_BNE   = 6'd24, OP_BLT   = 6'd25, OP_BLE   = 6'd26, OP_BGT   = 6'd27,
    OP_BGE   = 6'd28, OP_LIW   = 6'd29
  } opcode_t;

  typedef enum logic [3:0] {
    E_NOP  = 4'd0,  E_ADD  = 4'd1,  E_SUB   = 4'd2,  E_XOR  = 4'd3,
    E_AND  = 4'd4,  E_MOV  = 4'd5,  E_LOAD  = 4'd6,  E_STORE = 4'd7,
    E_FADD = 4'd8,  E_FSUB = 4'd9,  E_FMUL  = 4'd10, E_FDIV = 4'd11,
    E_FSQRT = 4'd12, E_FTOI = 4'd13, E_ITOF = 4'd14
  } etype_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  function automatic logic is_ctrl(input logic [5:0] op);
    case (op)
      OP_JUMP, OP_BLR, OP_BL, OP_BLRR, OP_BEQ, OP_BNE,
      OP_BLT, OP_BLE, OP_BGT, OP_BGE, OP_LIW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rb(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_FADD, OP_FSUB,
      OP_FMUL, OP_FDIV, OP_FSQRT, OP_FTOI, OP_ITOF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rt(input logic [5:0] op);
    return reads_rb(op) || op == OP_ADDI || op == OP_LI || op == OP_LIW ||
           op == OP_BL || op == OP_BLRR;
  endfunction

  function automatic etype_t etype_of(input logic [5:0] op);
    case (op)
      OP_ADD, OP_ADDI:            return E_ADD;
      OP_SUB:                     return E_SUB;
      OP_XOR:                     return E_XOR;
      OP_AND:                     return E_AND;
      OP_LI, OP_LIW, OP_BL, OP_BLRR: return E_MOV;
      OP_LOAD:                    return E_LOAD;
      OP_STORE:                   return E_STORE;
      OP_FADD:                    return E_FADD;
      OP_FSUB:                    return E_FSUB;
      OP_FMUL:                    return E_FMUL;
      OP_FDIV:                    return E_FDIV;
      OP_FSQRT:                   return E_FSQRT;
      OP_FTOI:                    return E_FTOI;
      OP_ITOF:                    return E_ITOF;
      default:                    return E_NOP;
    endcase
  endfunction

  // Single-precision a < b; +0 and -0 compare equal.
  function automatic logic fless(input logic [31:0] a, input logic [31:0] b);
    logic both_zero;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (a[31] != b[31]) return a[31] && !both_zero;
    if (a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

endpackage

// File: rtl/lane_dec.sv
// Single-lane decode: operand fetch from the flat register file, execute type,
// destination register and memory request fields.
module lane_dec
  import inst_package::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]        inst,
  input  logic [32*XLEN-1:0] gpr,
  input  logic [31:0]        pc,
  input  logic [31:0]        liw_word,
  output logic [XLEN-1:0]    srca,
  output logic [XLEN-1:0]    srcb,
  output logic [XLEN-1:0]    srcs,
  output logic [3:0]         e_type,
  output logic [4:0]         rt,
  output logic               rt_flag,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_din,
  output logic [3:0]         mem_we,
  output logic               uses_rb
);
  logic [5:0]      op;
  logic [4:0]      rs, ra, rb;
  logic [XLEN-1:0] si, reg_a, reg_b, reg_s;
  logic            links;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign ra    = inst[20:16];
  assign rb    = inst[15:11];
  assign si    = XLEN'($signed(inst[15:0]));
  assign reg_s = gpr[rs*XLEN +: XLEN];
  assign reg_a = gpr[ra*XLEN +: XLEN];
  assign reg_b = gpr[rb*XLEN +: XLEN];
  assign links = (op == OP_BL) || (op == OP_BLRR);

  always_comb begin
    srcb = si;
    if (reads_rb(op))      srcb = reg_b;
    else if (links)        srcb = XLEN'(pc + 32'd1);
    else if (op == OP_LIW) srcb = XLEN'(liw_word);
  end

  assign uses_rb  = reads_rb(op);
  assign srca     = reg_a;
  assign srcs     = reg_s;
  assign e_type   = etype_of(op);
  assign rt       = links ? 5'd31 : rs;
  assign rt_flag  = writes_rt(op);
  assign mem_addr = reg_a + si;
  assign mem_din  = reg_s;
  assign mem_we   = (op == OP_STORE) ? 4'b1111 : 4'b0000;

endmodule

// File: rtl/vliw_decode.sv
// VLIW bundle decoder: lane squashing, load-use scoreboard, compare flags,
// branch resolution with a fixed shadow, and a one-deep output register.
module vliw_decode
  import inst_package::*;
#(
  parameter int LANES     = 2,
  parameter int XLEN      = 32,
  parameter int LOAD_LAT  = 2,
  parameter int BR_SHADOW = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [32*XLEN-1:0]    gpr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [32*LANES-1:0]   in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [32*LANES-1:0]   out_inst,
  output logic [LANES*XLEN-1:0] srca,
  output logic [LANES*XLEN-1:0] srcb,
  output logic [LANES*XLEN-1:0] srcs,
  output logic [LANES*4-1:0]    e_type,
  output logic [LANES*5-1:0]    rt,
  output logic [LANES-1:0]      rt_flag,
  output logic [LANES*XLEN-1:0] mem_addr,
  output logic [LANES*XLEN-1:0] mem_din,
  output logic [LANES*4-1:0]    mem_we,
  output logic                  branch_flag,
  output logic [31:0]           branch_pc
);
  logic [5:0]            op0;
  logic                  ctrl0;
  logic [31:0]           liw_word;
  logic [32*LANES-1:0]   eff_inst;
  logic [LANES*XLEN-1:0] d_srca, d_srcb, d_srcs, d_addr, d_din;
  logic [LANES*4-1:0]    d_etype, d_we;
  logic [LANES*5-1:0]    d_rt;
  logic [LANES-1:0]      d_rtf, d_uses_rb;

  logic [2:0]  sb_cnt [32];
  logic [1:0]  shadow_cnt;
  logic        eq, less;
  logic        hazard, accept, live, taken;
  logic [31:0] target, load_set;
  logic        cmp_eq, cmp_less;
  logic [XLEN-1:0] cmp_a, cmp_b;
  logic [31:0] cmp_fa, cmp_fb;

  assign op0   = in_inst[31:26];
  assign ctrl0 = is_ctrl(op0);

  if (LANES >= 2) begin : g_liw
    assign liw_word = in_inst[63:32];
  end else begin : g_no_liw
    assign liw_word = 32'($signed(in_inst[15:0]));
  end

  // Lanes above 0 become Nop when they hold a control op or lane 0 does.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    if (k == 0) begin : g_l0
      assign eff_inst[31:0] = in_inst[31:0];
    end else begin : g_ln
      assign eff_inst[k*32 +: 32] = (ctrl0 || is_ctrl(in_inst[k*32+26 +: 6])) ?
                                    NOP_INST : in_inst[k*32 +: 32];
    end
    lane_dec #(.XLEN(XLEN)) u_dec (
      .inst(eff_inst[k*32 +: 32]), .gpr(gpr), .pc(in_pc), .liw_word(liw_word),
      .srca(d_srca[k*XLEN +: XLEN]), .srcb(d_srcb[k*XLEN +: XLEN]),
      .srcs(d_srcs[k*XLEN +: XLEN]), .e_type(d_etype[k*4 +: 4]),
      .rt(d_rt[k*5 +: 5]), .rt_flag(d_rtf[k]),
      .mem_addr(d_addr[k*XLEN +: XLEN]), .mem_din(d_din[k*XLEN +: XLEN]),
      .mem_we(d_we[k*4 +: 4]), .uses_rb(d_uses_rb[k])
    );
  end

  always_comb begin
    hazard   = 1'b0;
    load_set = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sb_cnt[eff_inst[k*32+16 +: 5]] != 3'd0 || sb_cnt[eff_inst[k*32+21 +: 5]] != 3'd0 ||
          (d_uses_rb[k] && sb_cnt[eff_inst[k*32+11 +: 5]] != 3'd0))
        hazard = 1'b1;
      if (d_etype[k*4 +: 4] == E_LOAD && d_rt[k*5 +: 5] != 5'd0)
        load_set[d_rt[k*5 +: 5]] = 1'b1;
    end
    hazard = hazard && in_valid;
  end

  assign in_ready = (out_ready && !hazard && shadow_cnt == 2'd0) || shadow_cnt != 2'd0;
  assign accept   = in_valid && in_ready;
  assign live     = accept && shadow_cnt == 2'd0;

  // Flags seen here are those registered by earlier bundles.
  always_comb begin
    target = 32'(in_inst[25:0]);
    case (op0)
      OP_JUMP, OP_BL, OP_BLR, OP_BLRR: taken = 1'b1;
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = less;
      OP_BLE:  taken = less || eq;
      OP_BGT:  taken = !less && !eq;
      OP_BGE:  taken = !less;
      default: taken = 1'b0;
    endcase
    if (op0 == OP_BLR)       target = 32'(gpr[31*XLEN +: XLEN]);
    else if (op0 == OP_BLRR) target = 32'(d_srcs[XLEN-1:0]);
  end

  // Walk lanes high to low so the lowest-index compare has the last word.
  always_comb begin
    cmp_eq   = eq;
    cmp_less = less;
    cmp_a    = '0;
    cmp_b    = '0;
    cmp_fa   = '0;
    cmp_fb   = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      cmp_a  = d_srcs[k*XLEN +: XLEN];
      cmp_b  = (eff_inst[k*32+26 +: 6] == OP_CMPDI) ? d_srcb[k*XLEN +: XLEN] : d_srca[k*XLEN +: XLEN];
      cmp_fa = 32'(cmp_a);
      cmp_fb = 32'(cmp_b);
      case (eff_inst[k*32+26 +: 6])
        OP_CMPD, OP_CMPDI: begin
          cmp_eq   = cmp_a == cmp_b;
          cmp_less = $signed(cmp_a) < $signed(cmp_b);
        end
        OP_CMPF: begin
          cmp_eq   = (cmp_fa == cmp_fb) || (cmp_fa[30:23] == 8'd0 && cmp_fb[30:23] == 8'd0);
          cmp_less = fless(cmp_fa, cmp_fb);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= {LANES{NOP_INST}};
      srca        <= '0;
      srcb        <= '0;
      srcs        <= '0;
      e_type      <= {LANES{4'(E_NOP)}};
      rt          <= '0;
      rt_flag     <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= '0;
      branch_flag <= 1'b0;
      branch_pc   <= '0;
      eq          <= 1'b0;
      less        <= 1'b0;
      shadow_cnt  <= 2'd0;
      for (int r = 0; r < 32; r++) sb_cnt[r] <= 3'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (live && load_set[r])   sb_cnt[r] <= 3'(LOAD_LAT);
        else if (sb_cnt[r] != 3'd0) sb_cnt[r] <= sb_cnt[r] - 3'd1;
      end
      if (live) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_inst    <= eff_inst;
        srca        <= d_srca;
        srcb        <= d_srcb;
        srcs        <= d_srcs;
        e_type      <= d_etype;
        rt          <= d_rt;
        rt_flag     <= d_rtf;
        mem_addr    <= d_addr;
        mem_din     <= d_din;
        mem_we      <= d_we;
        branch_flag <= taken;
        branch_pc   <= target;
        eq          <= cmp_eq;
        less        <= cmp_less;
        shadow_cnt  <= taken ? 2'(BR_SHADOW) : 2'd0;
      end else begin
        if (accept) shadow_cnt <= shadow_cnt - 2'd1;
        if (out_ready) begin
          out_valid   <= 1'b0;
          branch_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/vliw_decode.md
VLIW_DECODE -- requirements
Module: vliw_decode

Interface
REQ-001 SHALL have parameters: LANES, default 2, issue width (1..4); XLEN, default 32, datapath width; LOAD_LAT, default 2, load-to-use cycles (1..7); BR_SHADOW, default 1, bundles squashed after a taken branch (0..3).
REQ-002 SHALL have ports, in order: clk  in  1  clock; rstn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have gpr  in  32*XLEN  flat register file, reg r at bits [r*XLEN +: XLEN].
REQ-004 SHALL have in_valid  in  1, in_ready  out  1, in_pc  in  32, in_inst  in  32*LANES (lane k at [k*32 +: 32]).
REQ-005 SHALL have out_valid  out  1, out_ready  in  1, out_pc  out  32, out_inst  out  32*LANES.
REQ-006 SHALL have per-lane packed outputs: srca, srcb, srcs  XLEN each; e_type  4; rt  5; rt_flag  1; mem_addr  XLEN; mem_din  XLEN; mem_we  4.
REQ-007 SHALL have branch_flag  out  1 and branch_pc  out  32.

Function
REQ-008 Opcode = inst[31:26], rs = [25:21], ra = [20:16], rb = [15:11], si = sign-extended [15:0], li = zero-extended [25:0].
REQ-009 Bundle accepted iff in_valid && in_ready; in_ready = out_ready && !hazard && shadow_cnt==0 || shadow_cnt!=0.
REQ-010 Latency 1: accepted bundle appears on outputs next cycle with out_valid=1; if out_ready=0, all outputs hold.
REQ-011 srcb = reg[rb] for Add/Sub/Xor/And/Fadd/Fsub/Fmul/Fdiv/Fsqrt/Ftoi/Itof; pc+1 for Bl/Blrr on lane 0; si otherwise.
REQ-012 e_type mapping as package table; unknown opcodes give ENop, rt_flag=0, mem_we=0.
REQ-013 Control ops (Jump, Blr, Bl, Blrr, Beq, Bne, Blt, Ble, Bgt, Bge, Liw) only valid in lane 0; in other lanes they decode as Nop.
REQ-014 Liw in lane 0 (LANES>=2): srcb = lane-1 word, rt_flag=1; lane 1 output forced to Nop.
REQ-015 Lane 0 control op forces lanes 1..LANES-1 to Nop, with rt_flag=0 and mem_we=0.
REQ-016 rt = 31 for Bl/Blrr, else rs; rt_flag=1 for ALU ops, Li, Liw, Bl, Blrr; Load gives rt_flag=0.
REQ-017 mem_addr = reg[ra]+si (mod 2^XLEN); mem_din = reg[rs]; mem_we = 4'b1111 only for Store.
REQ-018 Cmpd/Cmpdi/Cmpf update eq/less flags at bundle accept; lowest-index lane wins if several compares are present.
REQ-019 Cmpf eq is also true when both exponents are zero; Cmpf less uses fless.
REQ-020 Conditional branches use flags registered by earlier bundles; a compare in the same bundle is not visible.
REQ-021 Taken branch: branch_flag=1 for exactly one cycle, with the output bundle; branch_pc = li (Jump/Bl/B*), reg[31] (Blr), or reg[rs] (Blrr).
REQ-022 After a taken branch, the next BR_SHADOW accepted bundles SHALL be discarded: in_ready=1, out_valid=0, no flag or scoreboard update.
REQ-023 Scoreboard: a per-register 3-bit countdown is set to LOAD_LAT on Load accept (rt!=0) and decrements each cycle to 0.
REQ-024 hazard=1 when any lane reads ra/rb/rs with a nonzero count; on hazard, out_valid=0 bubble and in_ready=0.
REQ-025 Two lanes loading the same rt in one bundle: count = LOAD_LAT (idempotent).
REQ-026 Register 0 is never tracked.

Reset
REQ-027 While rstn=0: out_valid, branch_flag, rt_flag, mem_we, eq, less = 0; e_type=ENop; out_inst = all Nop; out_pc=0; scoreboard and shadow_cnt cleared.
REQ-028 Reset mid-shadow or mid-hazard SHALL abandon the state; first post-reset bundle is accepted normally.

Structure
REQ-029 Opcode enum, e_type enum and Nop encoding SHALL live in shared inst_package; LANES-independent.
REQ-030 One sub-module lane_dec (single-lane operand/e_type/rt/mem decode) SHALL be instantiated LANES times; fless reused for Cmpf.

Verification
REQ-031 Lane0 Addi r3,r1,5 with r1=10 -> next cycle srca=10, srcb=5, e_type=EAdd, rt=3, rt_flag=1.
REQ-032 Cmpdi r1,7 (r1=7), then Beq 0x40 -> branch_flag=1 one cycle, branch_pc=0x40; next bundle (BR_SHADOW=1) out_valid=0.
REQ-033 Load r4 then Add r5,r4,r4 (LOAD_LAT=2) -> two bubble cycles with in_ready=0, then Add issues.
REQ-034 Liw lane0 with lane1=0xDEADBEEF -> srcb=0xDEADBEEF, lane1 e_type=ENop, rt_flag=0.
REQ-035 out_ready=0 for 3 cycles -> outputs and flags unchanged; rstn=0 during shadow -> all outputs at reset values.
